// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared encodings, field positions and decoded-instruction type for id_stage
package id_pkg;

    typedef enum logic [1:0] {
        CLS_R  = 2'b00,
        CLS_I  = 2'b01,
        CLS_ST = 2'b10,
        CLS_BR = 2'b11
    } cls_e;

    localparam int CLS_HI  = 15;
    localparam int CLS_LO  = 14;
    localparam int OP_HI   = 15;
    localparam int OP_LO   = 11;
    localparam int RS_HI   = 10;
    localparam int RS_LO   = 8;
    localparam int RT_HI   = 7;
    localparam int RT_LO   = 5;
    localparam int RD_HI   = 4;
    localparam int RD_LO   = 2;
    localparam int IMM5_HI = 4;
    localparam int IMM8_HI = 7;

    localparam int SB_CNT_W = 2;

    typedef struct packed {
        logic        uses_rs;
        logic        uses_rt;
        logic        wr_en;
        logic [2:0]  rd;
        logic [15:0] imm;
    } dec_t;

endpackage

// File: rtl/id_decode.sv
// rtl/id_decode.sv - combinational instruction decoder producing source use, destination and immediate
module id_decode
    import id_pkg::*;
(
    input  logic [15:0] instr,
    output dec_t        dec
);

    cls_e cls;

    assign cls = cls_e'(instr[CLS_HI:CLS_LO]);

    always_comb begin
        dec         = '0;
        dec.uses_rs = 1'b1;
        case (cls)
            CLS_R: begin
                dec.uses_rt = 1'b1;
                dec.wr_en   = 1'b1;
                dec.rd      = instr[RD_HI:RD_LO];
            end
            CLS_I: begin
                dec.wr_en = 1'b1;
                dec.rd    = instr[RT_HI:RT_LO];
                dec.imm   = {{11{instr[IMM5_HI]}}, instr[IMM5_HI:0]};
            end
            CLS_ST: begin
                dec.uses_rt = 1'b1;
                dec.imm     = {{11{instr[IMM5_HI]}}, instr[IMM5_HI:0]};
            end
            default: begin
                dec.imm = {{8{instr[IMM8_HI]}}, instr[IMM8_HI:0]};
            end
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage with RAW scoreboard and ID/EX register; WB_BYPASS_EN enables same-cycle writeback bypass
module id_stage
    import id_pkg::*;
#(
    parameter int SB_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] if_instr,
    input  logic [15:0] if_pc,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic        flush,
    output logic [2:0]  rf_read1regsel,
    output logic [2:0]  rf_read2regsel,
    input  logic [15:0] rf_read1data,
    input  logic [15:0] rf_read2data,
    input  logic        wb_retire,
    input  logic        wb_write,
    input  logic [2:0]  wb_regsel,
    input  logic [15:0] wb_data,
    output logic        id_valid,
    input  logic        ex_ready,
    output logic [15:0] id_pc,
    output logic [4:0]  id_op,
    output logic [15:0] id_rs_data,
    output logic [15:0] id_rt_data,
    output logic [15:0] id_imm,
    output logic [2:0]  id_rd,
    output logic        id_wr_en,
    output logic        err
);

    dec_t                dec;
    logic [2:0]          rs, rt;
    logic [SB_CNT_W-1:0] sb_cnt      [8];
    logic [SB_CNT_W-1:0] sb_cnt_next [8];
    logic                rs_byp, rt_byp, hazard, accept, uflow;
    logic [15:0]         rs_data, rt_data;

    id_decode u_decode (
        .instr (if_instr),
        .dec   (dec)
    );

    assign rs             = if_instr[RS_HI:RS_LO];
    assign rt             = if_instr[RT_HI:RT_LO];
    assign rf_read1regsel = rs;
    assign rf_read2regsel = rt;

`ifdef WB_BYPASS_EN
    // A source whose only pending writer retires this cycle can issue with the bypassed value.
    assign rs_byp  = wb_retire && wb_write && (wb_regsel == rs) && (sb_cnt[rs] == SB_CNT_W'(1));
    assign rt_byp  = wb_retire && wb_write && (wb_regsel == rt) && (sb_cnt[rt] == SB_CNT_W'(1));
    assign rs_data = (wb_write && (wb_regsel == rs)) ? wb_data : rf_read1data;
    assign rt_data = (wb_write && (wb_regsel == rt)) ? wb_data : rf_read2data;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_data, wb_write};
    assign rs_byp    = 1'b0;
    assign rt_byp    = 1'b0;
    assign rs_data   = rf_read1data;
    assign rt_data   = rf_read2data;
`endif

    assign hazard = (dec.uses_rs && (sb_cnt[rs] != '0) && !rs_byp)
                 || (dec.uses_rt && (sb_cnt[rt] != '0) && !rt_byp)
                 || (dec.wr_en && (sb_cnt[dec.rd] == SB_CNT_W'(SB_MAX)));

    assign if_ready = !rst && !flush && !hazard && (!id_valid || ex_ready);
    assign accept   = if_valid && if_ready;

    // Net all increments and decrements per register; a net decrement past zero clamps and flags.
    always_comb begin : sb_upd
        logic [2:0] sum, sub;
        uflow = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sum = {1'b0, sb_cnt[i]} + {2'b00, accept && dec.wr_en && (dec.rd == 3'(i))};
            sub = {2'b00, wb_retire && (wb_regsel == 3'(i))}
                + {2'b00, flush && id_valid && id_wr_en && (id_rd == 3'(i))};
            if (sub > sum) begin
                sb_cnt_next[i] = '0;
                uflow          = 1'b1;
            end else begin
                sb_cnt_next[i] = SB_CNT_W'(sum - sub);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) sb_cnt[i] <= '0;
            err <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) sb_cnt[i] <= sb_cnt_next[i];
            err <= err | uflow;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid   <= 1'b0;
            id_pc      <= '0;
            id_op      <= '0;
            id_rs_data <= '0;
            id_rt_data <= '0;
            id_imm     <= '0;
            id_rd      <= '0;
            id_wr_en   <= 1'b0;
        end else if (accept) begin
            id_valid   <= 1'b1;
            id_pc      <= if_pc;
            id_op      <= if_instr[OP_HI:OP_LO];
            id_rs_data <= rs_data;
            id_rt_data <= rt_data;
            id_imm     <= dec.imm;
            id_rd      <= dec.rd;
            id_wr_en   <= dec.wr_en;
        end else if (ex_ready || flush) begin
            id_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;

    logic        clk, rst;
    logic [15:0] if_instr, if_pc;
    logic        if_valid, if_ready, flush;
    logic [2:0]  rf_read1regsel, rf_read2regsel;
    logic [15:0] rf_read1data, rf_read2data;
    logic        wb_retire, wb_write;
    logic [2:0]  wb_regsel;
    logic [15:0] wb_data;
    logic        id_valid, ex_ready;
    logic [15:0] id_pc;
    logic [4:0]  id_op;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic [2:0]  id_rd;
    logic        id_wr_en, err;

    int checks = 0;
    int errors = 0;

    id_stage dut (
        .clk(clk), .rst(rst), .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
        .if_ready(if_ready), .flush(flush), .rf_read1regsel(rf_read1regsel),
        .rf_read2regsel(rf_read2regsel), .rf_read1data(rf_read1data), .rf_read2data(rf_read2data),
        .wb_retire(wb_retire), .wb_write(wb_write), .wb_regsel(wb_regsel), .wb_data(wb_data),
        .id_valid(id_valid), .ex_ready(ex_ready), .id_pc(id_pc), .id_op(id_op),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_rd(id_rd),
        .id_wr_en(id_wr_en), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_instr = '0; if_pc = '0; if_valid = 1'b0; flush = 1'b0;
        rf_read1data = '0; rf_read2data = '0; wb_retire = 1'b0; wb_write = 1'b0;
        wb_regsel = '0; wb_data = '0; ex_ready = 1'b0;
        step(); step();
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL rst_if_ready got %b exp 0", if_ready); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid got %b exp 0", id_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
        checks++; if (id_pc !== 16'h0) begin errors++; $display("FAIL rst_id_pc got %h exp 0000", id_pc); end
        checks++; if (dut.sb_cnt[5] !== 2'd0) begin errors++; $display("FAIL rst_cnt5 got %0d exp 0", dut.sb_cnt[5]); end
        rst = 1'b0;
    endtask

    task automatic test_r_type();
        if_instr = 16'h0014; if_pc = 16'h0100; if_valid = 1'b1; ex_ready = 1'b1;
        rf_read1data = 16'h1111; rf_read2data = 16'h3333;
        #1;
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL r_if_ready got %b exp 1", if_ready); end
        checks++; if (rf_read2regsel !== 3'd0) begin errors++; $display("FAIL r_sel2 got %0d exp 0", rf_read2regsel); end
        step();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL r_id_valid got %b exp 1", id_valid); end
        checks++; if (id_rd !== 3'd5) begin errors++; $display("FAIL r_id_rd got %0d exp 5", id_rd); end
        checks++; if (id_wr_en !== 1'b1) begin errors++; $display("FAIL r_wr_en got %b exp 1", id_wr_en); end
        checks++; if (id_pc !== 16'h0100) begin errors++; $display("FAIL r_id_pc got %h exp 0100", id_pc); end
        checks++; if (id_rt_data !== 16'h3333) begin errors++; $display("FAIL r_rt_data got %h exp 3333", id_rt_data); end
        checks++; if (id_imm !== 16'h0000) begin errors++; $display("FAIL r_imm got %h exp 0000", id_imm); end
        checks++; if (dut.sb_cnt[5] !== 2'd1) begin errors++; $display("FAIL r_cnt5 got %0d exp 1", dut.sb_cnt[5]); end
    endtask

    task automatic test_back_to_back();
        if_instr = 16'h4523; if_pc = 16'h0102;
        #1;
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b exp 0", if_ready); end
        checks++; if (rf_read1regsel !== 3'd5) begin errors++; $display("FAIL b2b_sel1 got %0d exp 5", rf_read1regsel); end
        step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", id_valid); end
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall2 got %b exp 0", if_ready); end
        wb_retire = 1'b1; wb_write = 1'b1; wb_regsel = 3'd5; wb_data = 16'hBEEF;
        #1;
`ifdef WB_BYPASS_EN
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL b2b_byp_ready got %b exp 1", if_ready); end
        step();
        wb_retire = 1'b0; wb_write = 1'b0; rf_read1data = 16'hBEEF;
`else
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL b2b_nobyp_ready got %b exp 0", if_ready); end
        step();
        wb_retire = 1'b0; wb_write = 1'b0; rf_read1data = 16'hBEEF;
        checks++; if (dut.sb_cnt[5] !== 2'd0) begin errors++; $display("FAIL b2b_cnt5_wb got %0d exp 0", dut.sb_cnt[5]); end
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL b2b_late_ready got %b exp 1", if_ready); end
        step();
`endif
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", id_valid); end
        checks++; if (id_rs_data !== 16'hBEEF) begin errors++; $display("FAIL b2b_rs_data got %h exp BEEF", id_rs_data); end
        checks++; if (id_rd !== 3'd1) begin errors++; $display("FAIL b2b_rd got %0d exp 1", id_rd); end
        checks++; if (id_imm !== 16'h0003) begin errors++; $display("FAIL b2b_imm got %h exp 0003", id_imm); end
        checks++; if (id_op !== 5'h08) begin errors++; $display("FAIL b2b_op got %h exp 08", id_op); end
        checks++; if (dut.sb_cnt[5] !== 2'd0) begin errors++; $display("FAIL b2b_cnt5 got %0d exp 0", dut.sb_cnt[5]); end
        checks++; if (dut.sb_cnt[1] !== 2'd1) begin errors++; $display("FAIL b2b_cnt1 got %0d exp 1", dut.sb_cnt[1]); end
    endtask

    task automatic test_hold();
        ex_ready = 1'b0; if_instr = 16'hC2F0; if_pc = 16'h0104; rf_read1data = 16'h2222;
        wb_retire = 1'b1; wb_write = 1'b1; wb_regsel = 3'd1; wb_data = 16'h5555;
        #1;
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL hold_ready got %b exp 0", if_ready); end
        checks++; if (rf_read1regsel !== 3'd2) begin errors++; $display("FAIL hold_sel1 got %0d exp 2", rf_read1regsel); end
        for (int k = 0; k < 3; k++) begin
            step();
            wb_retire = 1'b0; wb_write = 1'b0;
            checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %b exp 1", k, id_valid); end
            checks++; if (id_pc !== 16'h0102) begin errors++; $display("FAIL hold_pc[%0d] got %h exp 0102", k, id_pc); end
            checks++; if (id_rs_data !== 16'hBEEF) begin errors++; $display("FAIL hold_rs[%0d] got %h exp BEEF", k, id_rs_data); end
            checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got %b exp 0", k, if_ready); end
        end
        ex_ready = 1'b1;
        #1;
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL hold_release got %b exp 1", if_ready); end
        step();
        checks++; if (id_pc !== 16'h0104) begin errors++; $display("FAIL br_pc got %h exp 0104", id_pc); end
        checks++; if (id_op !== 5'h18) begin errors++; $display("FAIL br_op got %h exp 18", id_op); end
        checks++; if (id_imm !== 16'hFFF0) begin errors++; $display("FAIL br_imm got %h exp FFF0", id_imm); end
        checks++; if (id_wr_en !== 1'b0) begin errors++; $display("FAIL br_wr_en got %b exp 0", id_wr_en); end
        checks++; if (id_rs_data !== 16'h2222) begin errors++; $display("FAIL br_rs got %h exp 2222", id_rs_data); end
        checks++; if (dut.sb_cnt[1] !== 2'd0) begin errors++; $display("FAIL br_cnt1 got %0d exp 0", dut.sb_cnt[1]); end
    endtask

    task automatic test_flush();
        if_instr = 16'h407F; if_pc = 16'h0106;
        step();
        checks++; if (id_rd !== 3'd3) begin errors++; $display("FAIL fl_rd got %0d exp 3", id_rd); end
        checks++; if (id_imm !== 16'hFFFF) begin errors++; $display("FAIL fl_imm got %h exp FFFF", id_imm); end
        checks++; if (dut.sb_cnt[3] !== 2'd1) begin errors++; $display("FAIL fl_cnt3_pre got %0d exp 1", dut.sb_cnt[3]); end
        flush = 1'b1; if_instr = 16'h0014; if_pc = 16'h0108;
        #1;
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL fl_ready got %b exp 0", if_ready); end
        step();
        flush = 1'b0; if_valid = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got %b exp 0", id_valid); end
        checks++; if (dut.sb_cnt[3] !== 2'd0) begin errors++; $display("FAIL fl_cnt3 got %0d exp 0", dut.sb_cnt[3]); end
        checks++; if (dut.sb_cnt[5] !== 2'd0) begin errors++; $display("FAIL fl_cnt5 got %0d exp 0", dut.sb_cnt[5]); end
        checks++; if (id_pc !== 16'h0106) begin errors++; $display("FAIL fl_pc got %h exp 0106", id_pc); end
    endtask

    task automatic test_sb_max();
        if_valid = 1'b1; if_instr = 16'h4040; ex_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if_pc = 16'h0200 + 16'(k);
            #1;
            checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL max_ready[%0d] got %b exp 1", k, if_ready); end
            step();
        end
        checks++; if (dut.sb_cnt[2] !== 2'd3) begin errors++; $display("FAIL max_cnt2 got %0d exp 3", dut.sb_cnt[2]); end
        if_pc = 16'h0210;
        #1;
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL max_stall got %b exp 0", if_ready); end
        step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL max_drain got %b exp 0", id_valid); end
        wb_retire = 1'b1; wb_regsel = 3'd2;
        #1;
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL max_stall_ret got %b exp 0", if_ready); end
        step();
        wb_retire = 1'b0;
        #1;
        checks++; if (dut.sb_cnt[2] !== 2'd2) begin errors++; $display("FAIL max_cnt2_ret got %0d exp 2", dut.sb_cnt[2]); end
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL max_resume got %b exp 1", if_ready); end
        step();
        if_valid = 1'b0;
        checks++; if (id_pc !== 16'h0210) begin errors++; $display("FAIL max_pc got %h exp 0210", id_pc); end
        checks++; if (dut.sb_cnt[2] !== 2'd3) begin errors++; $display("FAIL max_cnt2_full got %0d exp 3", dut.sb_cnt[2]); end
        wb_retire = 1'b1; wb_regsel = 3'd2;
        step(); step(); step();
        wb_retire = 1'b0;
        checks++; if (dut.sb_cnt[2] !== 2'd0) begin errors++; $display("FAIL max_cnt2_end got %0d exp 0", dut.sb_cnt[2]); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL max_err got %b exp 0", err); end
    endtask

    task automatic test_underflow();
        wb_retire = 1'b1; wb_regsel = 3'd6;
        step();
        wb_retire = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL uf_err got %b exp 1", err); end
        checks++; if (dut.sb_cnt[6] !== 2'd0) begin errors++; $display("FAIL uf_cnt6 got %0d exp 0", dut.sb_cnt[6]); end
        step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b exp 1", err); end
        if_valid = 1'b1; if_instr = 16'h0014; if_pc = 16'h0300;
        step();
        rst = 1'b1;
        #1;
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL uf_rst_ready got %b exp 0", if_ready); end
        step();
        rst = 1'b0; if_valid = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL uf_rst_err got %b exp 0", err); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL uf_rst_valid got %b exp 0", id_valid); end
        checks++; if (dut.sb_cnt[5] !== 2'd0) begin errors++; $display("FAIL uf_rst_cnt5 got %0d exp 0", dut.sb_cnt[5]); end
        checks++; if (id_rd !== 3'd0) begin errors++; $display("FAIL uf_rst_rd got %0d exp 0", id_rd); end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_back_to_back();
        test_hold();
        test_flush();
        test_sb_max();
        test_underflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 16-bit, 8-register pipeline.
- Consumes an instruction from fetch and drives the register-file read selects. It then registers the decoded fields and operands into the ID/EX pipeline register.
- Contains a per-register scoreboard for RAW-hazard stalls and a same-cycle writeback bypass.
- Sits directly between fetch and the register file / execute.

Parameters:
- SB_MAX, 3, max in-flight writers per register (scoreboard counter saturation; counter width 2).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active high
- if_instr  in  16  instruction from fetch
- if_pc  in  16  PC of if_instr
- if_valid  in  1  if_instr valid
- if_ready  out  1  ID accepts if_instr this cycle
- flush  in  1  squash ID/EX register and current fetch instruction
- rf_read1regsel  out  3  = if_instr[10:8] (rs), combinational
- rf_read2regsel  out  3  = if_instr[7:5] (rt), combinational
- rf_read1data  in  16  register file port 1 data
- rf_read2data  in  16  register file port 2 data
- wb_retire  in  1  a scoreboarded instruction leaves the pipeline (written or squashed)
- wb_write  in  1  register file write this cycle (implies wb_retire)
- wb_regsel  in  3  destination of retiring instruction
- wb_data  in  16  writeback data
- id_valid  out  1  ID/EX register holds a valid instruction
- ex_ready  in  1  execute consumes ID/EX this cycle
- id_pc  out  16  registered PC
- id_op  out  5  registered if_instr[15:11]
- id_rs_data  out  16  operand A
- id_rt_data  out  16  operand B
- id_imm  out  16  sign-extended immediate
- id_rd  out  3  destination register
- id_wr_en  out  1  instruction writes id_rd
- err  out  1  sticky scoreboard underflow

Behaviour:
- Decode classes by if_instr[15:14]:
  - 00 R: reads rs and rt; writes rd = [4:2]; imm = 0.
  - 01 I: reads rs; writes rt; imm = sext([4:0]).
  - 10 store: reads rs and rt; no write; imm = sext([4:0]).
  - 11 branch: reads rs; no write; imm = sext([7:0]).
- Scoreboard: 8 x 2-bit counters; pending(r) = count(r) != 0.
- hazard = any used source pending, unless wb_retire && wb_write && wb_regsel == source && count(source) == 1 (bypass case).
- Also hazard if the destination count == SB_MAX.
- if_ready = !rst && !flush && !hazard && (!id_valid || ex_ready).
- Accept = if_valid && if_ready.
  - On accept, the ID/EX register loads next edge (latency 1).
  - id_valid <= 1.
- If not accepting and ex_ready, id_valid <= 0.
- If neither, hold all ID/EX outputs unchanged.
- Bypass: if wb_write && wb_regsel == rs, id_rs_data <= wb_data, else rf_read1data. Same rule for rt.
- Counter update per register, net of all events in the cycle:
  - +1 on accept with write to r.
  - -1 on wb_retire to r.
  - -1 on flush when id_valid && id_wr_en && id_rd == r.
  - Simultaneous +1/-1 leaves the count unchanged.
- Underflow (decrement at 0): counter stays 0 and err <= 1 until reset.
- Flush: id_valid <= 0 next edge, no accept that cycle; the scoreboard entry of the squashed ID/EX instruction is released as above.
- Reset (overrides flush and every other input):
  - id_valid, id_pc, id_op, id_rs_data, id_rt_data, id_imm, id_rd, id_wr_en, err = 0; all counters 0.
  - if_ready = 0 during reset.
  - Mid-operation reset discards everything in flight.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: same-cycle wb_data bypass and the bypass hazard exemption, as above.
- Undefined: no bypass; operands come only from rf_read*data. A source with count != 0 stalls even when its writeback is in the current cycle, which adds one stall cycle.

Decomposition:
- Package id_pkg holds:
  - class encodings (CLS_R=2'b00, CLS_I=2'b01, CLS_ST=2'b10, CLS_BR=2'b11);
  - field bit positions;
  - SB_CNT_W=2;
  - the decoded-instruction struct (uses_rs, uses_rt, wr_en, rd, imm).
- One combinational sub-module, id_decode: instr -> decoded struct.
- Scoreboard and pipeline register stay in id_stage.

Test Plan:
- Reset, then R-type 0x0014 (rs=0, rt=0, rd=5) with if_valid=1, ex_ready=1 -> if_ready=1; next cycle id_valid=1, id_rd=5, id_wr_en=1, count(5)=1.
- Back-to-back producer writes r5, consumer reads r5, no retire -> consumer stalls (if_ready=0, id_valid=0 after producer consumed). Then wb_retire=wb_write=1, wb_regsel=5, wb_data=0xBEEF -> same cycle accept; id_rs_data=0xBEEF with WB_BYPASS_EN, one extra stall cycle without it.
- ex_ready=0 for 3 cycles with id_valid=1 -> all ID/EX outputs hold, if_ready=0; ex_ready=1 -> the next instruction loads.
- Flush while ID/EX holds a writer of r3 (count(3)=1) -> id_valid=0 next cycle, count(3)=0, no accept in the flush cycle.
- Three unretired writers of r2, fourth writer presented -> if_ready=0 until one wb_retire to r2.
- wb_retire to r6 with count(6)=0 -> err=1 and stays 1; rst -> err=0.
